mem_bus_arbiter: RTL and testbench

//  Shares the single 256x16 RAM and the memory-mapped I/O (LEDR[7:0] write at 9'h100,
//  SW[7:0] read at 9'h140) between two requesters: port 0 (cpu) and port 1 (loader/debug).

---
 rtl/mem_bus_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing a 256x16 RAM and LED/switch I/O through an IDLE/ACCESS/DONE sequencer.
// Optional build macro MEM_BUS_ARB_FIXED_PRIO_EN: port 0 always wins simultaneous requests.
module mem_bus_arbiter #(
  parameter int AW  = 9,
  parameter int DW  = 16,
  parameter int RAW = 8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           req0_i,
  input  logic           req1_i,
  input  logic [1:0]     cmd0_i,
  input  logic [1:0]     cmd1_i,
  input  logic [AW-1:0]  addr0_i,
  input  logic [AW-1:0]  addr1_i,
  input  logic [DW-1:0]  wdata0_i,
  input  logic [DW-1:0]  wdata1_i,
  output logic           gnt0_o,
  output logic           gnt1_o,
  output logic           done0_o,
  output logic           done1_o,
  output logic [DW-1:0]  rdata_o,
  output logic [RAW-1:0] ram_addr_o,
  output logic           ram_write_o,
  output logic [DW-1:0]  ram_din_o,
  input  logic [DW-1:0]  ram_dout_i,
  input  logic [7:0]     sw_i,
  output logic [7:0]     ledr_o
);

  localparam logic [1:0]    MREAD    = 2'b01;
  localparam logic [1:0]    MWRITE   = 2'b10;
  localparam logic [AW-1:0] LED_ADDR = AW'(9'h100);
  localparam logic [AW-1:0] SW_ADDR  = AW'(9'h140);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t         state_q;
  logic           winner_q;
  logic           write_q;
  logic [AW-1:0]  addr_q;
  logic           gnt0_q;
  logic           gnt1_q;
  logic           done0_q;
  logic           done1_q;
  logic [DW-1:0]  rdata_q;
  logic [RAW-1:0] ram_addr_q;
  logic           ram_write_q;
  logic [DW-1:0]  ram_din_q;
  logic [7:0]     ledr_q;
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
  logic           rr_last_q;
`endif

  logic           valid0_d;
  logic           valid1_d;
  logic           grant_d;
  logic           port_d;
  logic [1:0]     sel_cmd_d;
  logic [AW-1:0]  sel_addr_d;
  logic [DW-1:0]  sel_wdata_d;

  // Source mux for the data returned on a completed access; writes always return zero.
  function automatic logic [DW-1:0] read_mux(
    input logic           is_write,
    input logic [AW-1:0]  addr,
    input logic [DW-1:0]  dout,
    input logic [7:0]     sw,
    input logic [7:0]     led
  );
    logic [DW-1:0] res;
    if (is_write) begin
      res = {DW{1'b0}};
    end else if (!addr[AW-1]) begin
      res = dout;
    end else if (addr == SW_ADDR) begin
      res = {{(DW-8){1'b0}}, sw};
    end else if (addr == LED_ADDR) begin
      res = {{(DW-8){1'b0}}, led};
    end else begin
      res = {DW{1'b0}};
    end
    return res;
  endfunction

  // Request qualification and winner selection.
  always_comb begin
    valid0_d = req0_i && ((cmd0_i == MREAD) || (cmd0_i == MWRITE));
    valid1_d = req1_i && ((cmd1_i == MREAD) || (cmd1_i == MWRITE));
    grant_d  = valid0_d | valid1_d;
`ifdef MEM_BUS_ARB_FIXED_PRIO_EN
    port_d   = ~valid0_d;
`else
    if (valid0_d && valid1_d) begin
      port_d = ~rr_last_q;
    end else if (valid1_d) begin
      port_d = 1'b1;
    end else begin
      port_d = 1'b0;
    end
`endif
  end

  // Route the winning requester's command, address and data.
  always_comb begin
    if (port_d) begin
      sel_cmd_d   = cmd1_i;
      sel_addr_d  = addr1_i;
      sel_wdata_d = wdata1_i;
    end else begin
      sel_cmd_d   = cmd0_i;
      sel_addr_d  = addr0_i;
      sel_wdata_d = wdata0_i;
    end
  end

  // Access sequencer with all outputs registered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      winner_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= {AW{1'b0}};
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata_q     <= {DW{1'b0}};
      ram_addr_q  <= {RAW{1'b0}};
      ram_write_q <= 1'b0;
      ram_din_q   <= {DW{1'b0}};
      ledr_q      <= 8'h00;
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
      rr_last_q   <= 1'b1;
`endif
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rdata_q <= {DW{1'b0}};
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= ACCESS;
            winner_q    <= port_d;
            gnt0_q      <= ~port_d;
            gnt1_q      <= port_d;
            write_q     <= (sel_cmd_d == MWRITE);
            addr_q      <= sel_addr_d;
            ram_addr_q  <= sel_addr_d[RAW-1:0];
            ram_din_q   <= sel_wdata_d;
            ram_write_q <= (sel_cmd_d == MWRITE) && !sel_addr_d[AW-1];
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          // The RAM commits the write on this edge, so the enable drops here.
          ram_write_q <= 1'b0;
          if (write_q && (addr_q == LED_ADDR)) begin
            ledr_q <= ram_din_q[7:0];
          end else begin
            ledr_q <= ledr_q;
          end
          state_q <= DONE;
        end
        DONE: begin
          done0_q <= ~winner_q;
          done1_q <= winner_q;
          rdata_q <= read_mux(write_q, addr_q, ram_dout_i, sw_i, ledr_q);
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
          rr_last_q <= winner_q;
`endif
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign done0_o     = done0_q;
  assign done1_o     = done1_q;
  assign rdata_o     = rdata_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_write_o = ram_write_q;
  assign ram_din_o   = ram_din_q;
  assign ledr_o      = ledr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a synchronous-read 256x16 RAM model.
module tb_mem_bus_arbiter;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  cmd0, cmd1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] rdata;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din, ram_dout;
  logic [7:0]  sw, ledr;
  logic [15:0] mem [256];

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  mem_bus_arbiter dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req0_i      (req0),
    .req1_i      (req1),
    .cmd0_i      (cmd0),
    .cmd1_i      (cmd1),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .done0_o     (done0),
    .done1_o     (done1),
    .rdata_o     (rdata),
    .ram_addr_o  (ram_addr),
    .ram_write_o (ram_write),
    .ram_din_o   (ram_din),
    .ram_dout_i  (ram_dout),
    .sw_i        (sw),
    .ledr_o      (ledr)
  );

  task automatic drop_reqs();
    req0 = 1'b0; cmd0 = MNONE;
    req1 = 1'b0; cmd1 = MNONE;
  endtask

  // One access on one port; lat = done cycle - gnt cycle (-1 on timeout), wrong = protocol anomaly.
  task automatic do_access(input logic port, input logic [1:0] cmd, input logic [8:0] addr,
                           input logic [15:0] wd, output int lat, output logic [15:0] rd,
                           output logic wrong);
    int c, gc, dc;
    c = 0; gc = -1; dc = -1; rd = 16'hDEAD; wrong = 1'b0;
    if (port) begin req1 = 1'b1; cmd1 = cmd; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; cmd0 = cmd; addr0 = addr; wdata0 = wd; end
    while (c < 20 && dc < 0) begin
      @(negedge clk);
      c++;
      if ((port ? gnt1 : gnt0) && gc < 0) begin gc = c; drop_reqs(); end
      if (port ? (gnt0 | done0) : (gnt1 | done1)) wrong = 1'b1;
      if (port ? done1 : done0) begin dc = c; rd = rdata; end
    end
    drop_reqs();
    if (gc != 1) wrong = 1'b1;
    lat = (gc > 0 && dc > 0) ? dc - gc : -1;
  endtask

  task automatic test_reset();
    int lat; logic [15:0] rd; logic wrong; logic seen_done;
    reset = 1'b1; drop_reqs();
    repeat (2) @(negedge clk);
    check_cnt++;
    if ({gnt0, gnt1, done0, done1} !== 4'b0000) $display("FAIL reset_pulses: got %b, required 0000", {gnt0, gnt1, done0, done1});
    else pass_cnt++;
    check_cnt++;
    if ({rdata, ram_din} !== 32'h0) $display("FAIL reset_data: rdata=%h ram_din=%h, required 0", rdata, ram_din);
    else pass_cnt++;
    check_cnt++;
    if ({ram_addr, ram_write, ledr} !== 17'h0) $display("FAIL reset_ram_ctl: addr=%h we=%b ledr=%h, required 0", ram_addr, ram_write, ledr);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    do_access(1'b0, MWRITE, 9'h005, 16'h5555, lat, rd, wrong);
    check_cnt++;
    if (lat !== 2 || wrong !== 1'b0) $display("FAIL pre_write_timing: lat=%0d wrong=%b, required lat=2 wrong=0", lat, wrong);
    else pass_cnt++;
    req0 = 1'b1; cmd0 = MWRITE; addr0 = 9'h005; wdata0 = 16'hBEEF;
    @(negedge clk);
    check_cnt++;
    if ({gnt0, ram_write, ram_addr, ram_din} !== {1'b1, 1'b1, 8'h05, 16'hBEEF})
      $display("FAIL access_outputs: gnt0=%b we=%b addr=%h din=%h, required 1 1 05 beef", gnt0, ram_write, ram_addr, ram_din);
    else pass_cnt++;
    #2 reset = 1'b1; drop_reqs();
    #1;
    check_cnt++;
    if (ram_write !== 1'b0) $display("FAIL reset_async_we: ram_write=%b, required 0", ram_write);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done0 | done1 | gnt0 | gnt1) seen_done = 1'b1;
    end
    check_cnt++;
    if (seen_done !== 1'b0 || ledr !== 8'h00) $display("FAIL reset_abort: pulse=%b ledr=%h, required 0 00", seen_done, ledr);
    else pass_cnt++;
    do_access(1'b0, MREAD, 9'h005, 16'h0000, lat, rd, wrong);
    check_cnt++;
    if (rd !== 16'h5555 || lat !== 2) $display("FAIL reset_ram_kept: rdata=%h lat=%0d, required 5555 lat=2", rd, lat);
    else pass_cnt++;
  endtask

  task automatic test_ram_rw();
    int lat; logic [15:0] rd; logic wrong;
    do_access(1'b0, MWRITE, 9'h010, 16'h1234, lat, rd, wrong);
    check_cnt++;
    if (lat !== 2 || wrong !== 1'b0 || rd !== 16'h0000) $display("FAIL p0_write: lat=%0d wrong=%b rdata=%h, required 2 0 0000", lat, wrong, rd);
    else pass_cnt++;
    do_access(1'b0, MREAD, 9'h010, 16'h0000, lat, rd, wrong);
    check_cnt++;
    if (lat !== 2 || wrong !== 1'b0 || rd !== 16'h1234) $display("FAIL p0_read: lat=%0d wrong=%b rdata=%h, required 2 0 1234", lat, wrong, rd);
    else pass_cnt++;
    do_access(1'b1, MWRITE, 9'h0FF, 16'hABCD, lat, rd, wrong);
    check_cnt++;
    if (lat !== 2 || wrong !== 1'b0) $display("FAIL p1_write_top: lat=%0d wrong=%b, required 2 0", lat, wrong);
    else pass_cnt++;
    do_access(1'b0, MREAD, 9'h0FF, 16'h0000, lat, rd, wrong);
    check_cnt++;
    if (rd !== 16'hABCD || wrong !== 1'b0) $display("FAIL p0_read_top: rdata=%h wrong=%b, required abcd 0", rd, wrong);
    else pass_cnt++;
  endtask

  task automatic test_io();
    int lat; logic [15:0] rd; logic wrong;
    do_access(1'b1, MWRITE, 9'h100, 16'hFFA5, lat, rd, wrong);
    check_cnt++;
    if (ledr !== 8'hA5 || lat !== 2 || rd !== 16'h0000) $display("FAIL led_write: ledr=%h lat=%0d rdata=%h, required a5 2 0000", ledr, lat, rd);
    else pass_cnt++;
    sw = 8'h3C;
    do_access(1'b0, MREAD, 9'h140, 16'h0000, lat, rd, wrong);
    check_cnt++;
    if (rd !== 16'h003C || wrong !== 1'b0) $display("FAIL sw_read: rdata=%h wrong=%b, required 003c 0", rd, wrong);
    else pass_cnt++;
    do_access(1'b0, MREAD, 9'h1FF, 16'h0000, lat, rd, wrong);
    check_cnt++;
    if (rd !== 16'h0000 || lat !== 2) $display("FAIL io_unmapped_read: rdata=%h lat=%0d, required 0000 2", rd, lat);
    else pass_cnt++;
    do_access(1'b0, MWRITE, 9'h1FF, 16'h1111, lat, rd, wrong);
    check_cnt++;
    if (ledr !== 8'hA5 || ram_write !== 1'b0) $display("FAIL io_unmapped_write: ledr=%h we=%b, required a5 0", ledr, ram_write);
    else pass_cnt++;
    do_access(1'b1, MREAD, 9'h100, 16'h0000, lat, rd, wrong);
    check_cnt++;
    if (rd !== 16'h00A5 || wrong !== 1'b0) $display("FAIL led_readback: rdata=%h wrong=%b, required 00a5 0", rd, wrong);
    else pass_cnt++;
  endtask

  task automatic test_mnone();
    int lat; logic [15:0] rd; logic wrong; logic activity;
    activity = 1'b0;
    req0 = 1'b1; cmd0 = MNONE; addr0 = 9'h010; wdata0 = 16'hDEAD;
    req1 = 1'b1; cmd1 = 2'b11; addr1 = 9'h100; wdata1 = 16'h0077;
    repeat (10) begin
      @(negedge clk);
      if (gnt0 | gnt1 | done0 | done1 | ram_write | (rdata != 16'h0000)) activity = 1'b1;
    end
    drop_reqs();
    check_cnt++;
    if (activity !== 1'b0 || ledr !== 8'hA5) $display("FAIL mnone_ignored: activity=%b ledr=%h, required 0 a5", activity, ledr);
    else pass_cnt++;
    do_access(1'b1, MREAD, 9'h010, 16'h0000, lat, rd, wrong);
    check_cnt++;
    if (rd !== 16'h1234 || lat !== 2) $display("FAIL mnone_ram_kept: rdata=%h lat=%0d, required 1234 2", rd, lat);
    else pass_cnt++;
  endtask

  task automatic test_arbitration();
    int seq_a[4]; int g_a[4]; logic [15:0] drd[4]; logic exp_seq[4];
    int ng, nd, c; logic both;
`ifdef MEM_BUS_ARB_FIXED_PRIO_EN
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b0; exp_seq[2] = 1'b0; exp_seq[3] = 1'b0;
`else
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;
`endif
    for (int i = 0; i < 4; i++) begin seq_a[i] = -1; g_a[i] = -1; drd[i] = 16'hDEAD; end
    ng = 0; nd = 0; c = 0; both = 1'b0;
    req0 = 1'b1; cmd0 = MREAD; addr0 = 9'h010;
    req1 = 1'b1; cmd1 = MREAD; addr1 = 9'h0FF;
    while (c < 60 && nd < 4) begin
      @(negedge clk);
      c++;
      if ((gnt0 & gnt1) | (done0 & done1)) both = 1'b1;
      if ((gnt0 | gnt1) && ng < 4) begin seq_a[ng] = gnt1 ? 1 : 0; g_a[ng] = c; ng++; end
      if (ng == 4) drop_reqs();
      if ((done0 | done1) && nd < 4) begin drd[nd] = rdata; nd++; end
    end
    drop_reqs();
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (seq_a[i] !== int'(exp_seq[i])) $display("FAIL arb_grant%0d: port=%0d, required %0d", i, seq_a[i], exp_seq[i]);
      else pass_cnt++;
      check_cnt++;
      if (drd[i] !== (exp_seq[i] ? 16'hABCD : 16'h1234))
        $display("FAIL arb_rdata%0d: rdata=%h, required %h", i, drd[i], exp_seq[i] ? 16'hABCD : 16'h1234);
      else pass_cnt++;
    end
    check_cnt++;
    if (both !== 1'b0 || (g_a[3] - g_a[2]) !== 3) $display("FAIL arb_exclusive_rate: overlap=%b spacing=%0d, required 0 3", both, g_a[3] - g_a[2]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c, g0, d0, g1, d1; logic [15:0] rd;
    c = 0; g0 = -1; d0 = -1; g1 = -1; d1 = -1; rd = 16'hDEAD;
    req0 = 1'b1; cmd0 = MWRITE; addr0 = 9'h020; wdata0 = 16'h0F0F;
    while (c < 20 && d1 < 0) begin
      @(negedge clk);
      c++;
      if (gnt0 && g0 < 0) begin
        g0 = c; req0 = 1'b0; cmd0 = MNONE;
        req1 = 1'b1; cmd1 = MREAD; addr1 = 9'h010;
      end
      if (done0) d0 = c;
      if (gnt1 && g1 < 0) begin g1 = c; req1 = 1'b0; cmd1 = MNONE; end
      if (done1) begin d1 = c; rd = rdata; end
    end
    drop_reqs();
    check_cnt++;
    if (d0 - g0 !== 2) $display("FAIL b2b_done0: gnt0=%0d done0=%0d, required spacing 2", g0, d0);
    else pass_cnt++;
    check_cnt++;
    if (g1 !== d0 + 1) $display("FAIL b2b_gnt1_wait: gnt1=%0d, required %0d", g1, d0 + 1);
    else pass_cnt++;
    check_cnt++;
    if (d1 - g1 !== 2 || rd !== 16'h1234) $display("FAIL b2b_done1: spacing=%0d rdata=%h, required 2 1234", d1 - g1, rd);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sw = 8'h00;
    req0 = 1'b0; cmd0 = MNONE; addr0 = 9'h000; wdata0 = 16'h0000;
    req1 = 1'b0; cmd1 = MNONE; addr1 = 9'h000; wdata1 = 16'h0000;
    test_reset();
    test_ram_rw();
    test_io();
    test_mnone();
    test_arbitration();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
